// File: rtl/note_if.sv
// Tone input and decoded-note outputs of the note decoder.
// note_strobe is a one-cycle pulse, coincident with the cycle the new
// {note_valid, note_num, octave} triple first appears; there is no back-pressure.
interface note_if;
  logic        tone_in;
  logic        note_valid;
  logic [3:0]  note_num;
  logic [1:0]  octave;
  logic        note_strobe;
  logic [23:0] period_out;

  modport master (
    output tone_in,
    input  note_valid, note_num, octave, note_strobe, period_out
  );

  modport slave (
    input  tone_in,
    output note_valid, note_num, octave, note_strobe, period_out
  );
endinterface

// File: rtl/note_decoder.sv
// Measures the period of a square-wave tone, matches it against a 3-octave
// scale table and reports the note once it has been seen CONFIRM_COUNT times.
module note_decoder #(
  parameter int CLK_FREQ       = 50000000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CONFIRM_COUNT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  note_if.slave      bus,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    SCAN    = 2'd1,
    CONFIRM = 2'd2
  } state_t;

  localparam logic [23:0] TIMEOUT  = 24'(TIMEOUT_CYCLES);
  localparam logic [7:0]  CONF_MAX = 8'(CONFIRM_COUNT);
  localparam logic [4:0]  LAST_IDX = 5'd20;

  // Every branch is a constant, so this folds into a small ROM.
  function automatic logic [23:0] ref_period(input logic [4:0] k);
    case (k)
      5'd0:  return 24'(CLK_FREQ / 131);
      5'd1:  return 24'(CLK_FREQ / 147);
      5'd2:  return 24'(CLK_FREQ / 165);
      5'd3:  return 24'(CLK_FREQ / 175);
      5'd4:  return 24'(CLK_FREQ / 196);
      5'd5:  return 24'(CLK_FREQ / 220);
      5'd6:  return 24'(CLK_FREQ / 247);
      5'd7:  return 24'(CLK_FREQ / 262);
      5'd8:  return 24'(CLK_FREQ / 294);
      5'd9:  return 24'(CLK_FREQ / 330);
      5'd10: return 24'(CLK_FREQ / 349);
      5'd11: return 24'(CLK_FREQ / 392);
      5'd12: return 24'(CLK_FREQ / 440);
      5'd13: return 24'(CLK_FREQ / 494);
      5'd14: return 24'(CLK_FREQ / 523);
      5'd15: return 24'(CLK_FREQ / 587);
      5'd16: return 24'(CLK_FREQ / 659);
      5'd17: return 24'(CLK_FREQ / 698);
      5'd18: return 24'(CLK_FREQ / 784);
      5'd19: return 24'(CLK_FREQ / 880);
      5'd20: return 24'(CLK_FREQ / 988);
      default: return 24'd0;
    endcase
  endfunction

  logic        sync1, sync2, sync2_d;
  logic        edge_det;
  logic [23:0] counter;
  logic        armed;
  logic        at_timeout, silence, capture;

  state_t      state, state_next;
  logic [4:0]  idx, idx_next;
  logic [4:0]  cand, cand_next;
  logic [4:0]  last_cand, last_cand_next;
  logic        last_valid, last_valid_next;
  logic [7:0]  confirm_cnt, cnt_next, cnt_new;

  logic        valid_next;
  logic [3:0]  num_next;
  logic [1:0]  oct_next;
  logic [23:0] period_next;

  logic [23:0] ref_p;
  logic [24:0] lo, hi, meas;
  logic        match;

  assign edge_det   = sync2 & ~sync2_d;
  assign at_timeout = (counter == TIMEOUT);
  assign silence    = at_timeout & armed;
  // An edge landing on a saturated counter follows silence, so it only re-arms.
  assign capture    = edge_det & armed & ~at_timeout;
  assign fsm_state  = state;

  assign ref_p = ref_period(idx);
  assign lo    = {1'b0, ref_p} - {7'd0, ref_p[23:6]};
  assign hi    = {1'b0, ref_p} + {7'd0, ref_p[23:6]};
  assign meas  = {1'b0, bus.period_out};
  assign match = (meas >= lo) && (meas <= hi);

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    cand_next       = cand;
    last_cand_next  = last_cand;
    last_valid_next = last_valid;
    cnt_next        = confirm_cnt;
    cnt_new         = confirm_cnt;
    valid_next      = bus.note_valid;
    num_next        = bus.note_num;
    oct_next        = bus.octave;
    period_next     = bus.period_out;

    case (state)
      WAIT: begin
        if (capture) begin
          period_next = counter + 24'd1;
          idx_next    = 5'd0;
          state_next  = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          cand_next  = idx;
          state_next = CONFIRM;
        end else if (idx == LAST_IDX) begin
          cnt_next   = 8'd0;
          valid_next = 1'b0;
          num_next   = 4'd0;
          oct_next   = 2'd0;
          state_next = WAIT;
        end else begin
          idx_next = idx + 5'd1;
        end
      end
      CONFIRM: begin
        if (last_valid && (cand == last_cand)) begin
          cnt_new = (confirm_cnt < CONF_MAX) ? confirm_cnt + 8'd1 : confirm_cnt;
        end else begin
          cnt_new = 8'd1;
        end
        cnt_next        = cnt_new;
        last_cand_next  = cand;
        last_valid_next = 1'b1;
        if (cnt_new >= CONF_MAX) begin
          valid_next = 1'b1;
          num_next   = 4'(cand % 5'd7) + 4'd1;
          oct_next   = 2'(cand / 5'd7) + 2'd1;
        end
        state_next = WAIT;
      end
      default: state_next = WAIT;
    endcase

    if (silence) begin
      state_next      = WAIT;
      cnt_next        = 8'd0;
      last_cand_next  = 5'd0;
      last_valid_next = 1'b0;
      valid_next      = 1'b0;
      num_next        = 4'd0;
      oct_next        = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1           <= 1'b0;
      sync2           <= 1'b0;
      sync2_d         <= 1'b0;
      counter         <= 24'd0;
      armed           <= 1'b0;
      state           <= WAIT;
      idx             <= 5'd0;
      cand            <= 5'd0;
      last_cand       <= 5'd0;
      last_valid      <= 1'b0;
      confirm_cnt     <= 8'd0;
      bus.note_valid  <= 1'b0;
      bus.note_num    <= 4'd0;
      bus.octave      <= 2'd0;
      bus.note_strobe <= 1'b0;
      bus.period_out  <= 24'd0;
    end else begin
      sync1   <= bus.tone_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (edge_det) begin
        counter <= 24'd0;
      end else if (!at_timeout) begin
        counter <= counter + 24'd1;
      end
      if (edge_det) begin
        armed <= 1'b1;
      end else if (silence) begin
        armed <= 1'b0;
      end
      state           <= state_next;
      idx             <= idx_next;
      cand            <= cand_next;
      last_cand       <= last_cand_next;
      last_valid      <= last_valid_next;
      confirm_cnt     <= cnt_next;
      bus.note_valid  <= valid_next;
      bus.note_num    <= num_next;
      bus.octave      <= oct_next;
      bus.period_out  <= period_next;
      bus.note_strobe <= ({valid_next, num_next, oct_next} !=
                          {bus.note_valid, bus.note_num, bus.octave});
    end
  end

endmodule

// File: doc/note_decoder.md
NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, cycles without a rising edge before silence is declared.
REQ-003 Parameter CONFIRM_COUNT, default 3, consecutive identical matches required before the output note updates.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tone_in  input  1  asynchronous square-wave tone to be decoded.
REQ-007 note_valid  output  1  a confirmed note is present.
REQ-008 note_num  output  4  decoded scale degree 1..7; 0 when not valid.
REQ-009 octave  output  2  1 low, 2 middle, 3 high; 0 when not valid.
REQ-010 note_strobe  output  1  one-cycle pulse whenever note_valid, note_num or octave changes.
REQ-011 period_out  output  24  last captured period in clk cycles.

Function
REQ-012 tone_in SHALL pass through a 2-flop synchronizer; edge_det SHALL be high on the cycle where sync2=1 and its previous value=0.
REQ-013 A 24-bit period counter SHALL clear to 0 on edge_det, otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-014 On edge_det with a measurement armed, P = counter+1 SHALL be captured into period_out; a square wave of exactly T cycles yields P=T.
REQ-015 The first edge after reset or silence SHALL only arm measurement; no period is captured.
REQ-016 Reference table: 21 entries, index 0..20, period_k = CLK_FREQ / f_k (integer division), f = 131,147,165,175,196,220,247, 262,294,330,349,392,440,494, 523,587,659,698,784,880,988 Hz.
REQ-017 Match rule: P matches entry k iff period_k - period_k/64 <= P <= period_k + period_k/64, with /64 an unsigned integer division.
REQ-018 FSM states: WAIT, SCAN, CONFIRM.
REQ-019 WAIT: on capture, go to SCAN with idx=0.
REQ-020 SCAN: compare one entry per cycle, in ascending idx order. A match goes to CONFIRM with cand=idx. No match at idx=20 is an unmatched period: clear confirm_cnt, force the not-valid output state, and return to WAIT.
REQ-021 CONFIRM: if cand equals last_cand, confirm_cnt increments (saturating); otherwise confirm_cnt=1 and last_cand=cand. Return to WAIT.
REQ-022 When confirm_cnt reaches CONFIRM_COUNT, outputs SHALL load note_num=cand%7+1 and octave=cand/7+1, and note_valid=1.
REQ-023 Latency: outputs and note_strobe update k+3 cycles after the capturing edge_det cycle, where k is the matched index.
REQ-024 A capture arriving while in SCAN or CONFIRM SHALL be dropped; the counter still clears.
REQ-025 When the counter reaches TIMEOUT_CYCLES, the block SHALL enter the not-valid output state, clear confirm_cnt and last_cand, and disarm measurement.
REQ-026 Not-valid output state: note_valid=0, note_num=0, octave=0.
REQ-027 note_strobe SHALL pulse only when the registered output triple actually changes; re-confirming the same note or repeated timeouts produce no pulse.
REQ-028 period_out SHALL hold its value through silence and update only on capture.

Reset
REQ-029 While rst=1: note_valid=0, note_num=0, octave=0, note_strobe=0, period_out=0, counter=0, FSM=WAIT, confirm_cnt=0, last_cand invalid, measurement disarmed, synchronizer flops=0.
REQ-030 Reset asserted mid-measurement or mid-SCAN SHALL discard all partial state; the first edge after release only arms measurement.

Verification
REQ-031 Square wave of period 113636 (440 Hz), 4 rising edges -> after the 4th edge, note_num=6, octave=2, note_valid=1, exactly one strobe, period_out=113636.
REQ-032 Periods 113636+1775 -> match (note 6, octave 2); periods 113636+1800 -> unmatched, note_valid stays 0, no strobe.
REQ-033 Confirmed 440 Hz, then tone_in held low -> 1000000 cycles after the last edge_det: note_valid=0, note_num=0, one strobe; period_out unchanged.
REQ-034 Confirmed note 6/oct 2, switch to period 95602 (523 Hz) -> after 3 new periods: note_num=1, octave=3, one strobe, note_valid never drops.
REQ-035 Alternating periods 113636/95602 -> confirm_cnt never exceeds 1, outputs never become valid.
REQ-036 rst pulsed during the 2nd period of a 262 Hz tone (190839 cycles) -> all outputs 0; valid returns only after 4 further edges.
